// File: rtl/store_size_pkg.sv
// Shared store-size codes and FSM state encoding
// for the store merge unit.
package store_size_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: overlays half/byte store data
// onto the captured memory word at the given byte offset.
module store_lane_merge
    import store_size_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] i_old,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [1:0]        i_size,
    input  logic [OFF_W-1:0]  i_off,
    output logic [DATA_W-1:0] o_merged
);

    localparam logic [DATA_W-1:0] HALF_M = DATA_W'(16'hFFFF);
    localparam logic [DATA_W-1:0] BYTE_M = DATA_W'(8'hFF);

    logic [OFF_W+2:0]  w_sh;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_data;

    assign w_sh = {i_off, 3'b000};

    always_comb begin
        w_mask = '1;
        w_data = i_wdata;
        unique case (1'b1)
            (i_size == SZ_HALF): begin
                w_mask = HALF_M << w_sh;
                w_data = (i_wdata & HALF_M) << w_sh;
            end
            (i_size == SZ_BYTE): begin
                w_mask = BYTE_M << w_sh;
                w_data = (i_wdata & BYTE_M) << w_sh;
            end
            default: begin
            end
        endcase
        o_merged = (i_old & ~w_mask) | (w_data & w_mask);
    end

endmodule

// File: rtl/store_merge_unit.sv
// Sequential store unit: word stores write directly,
// half/byte stores run read-modify-write on the memory port.
module store_merge_unit
    import store_size_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              misalign
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_size;
    logic [CNT_W-1:0]  r_lat_cnt;

    logic [OFF_W-1:0]  w_in_off;
    logic              w_in_ok;
    logic              w_read_last;
    logic              w_accept;
    logic [DATA_W-1:0] w_merged;
    logic [ADDR_W-1:0] w_word_addr;

    assign w_in_off    = addr[OFF_W-1:0];
    assign w_accept    = (r_state == IDLE) && start;
    assign w_read_last = (r_state == READ) && (r_lat_cnt == LAST_CNT);
    assign w_word_addr = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        w_in_ok = 1'b0;
        unique case (1'b1)
            (size == SZ_WORD): w_in_ok = (w_in_off == '0);
            (size == SZ_HALF): w_in_ok = ~w_in_off[0];
            (size == SZ_BYTE): w_in_ok = 1'b1;
            default:           w_in_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (!w_in_ok)
                        w_next = ERR;
                    else if (size == SZ_WORD)
                        w_next = WRITE;
                    else
                        w_next = READ;
                end
            end
            READ:    if (w_read_last) w_next = WRITE;
            WRITE:   w_next = DONE;
            DONE:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_size    <= '0;
            r_rdata   <= '0;
            r_lat_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_size  <= size;
            end
            if (r_state == READ)
                r_lat_cnt <= w_read_last ? '0 : r_lat_cnt + 1'b1;
            else
                r_lat_cnt <= '0;
            if (w_read_last)
                r_rdata <= mem_rdata;
        end
    end

    store_lane_merge #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_merge (
        .i_old    (r_rdata),
        .i_wdata  (r_wdata),
        .i_size   (r_size),
        .i_off    (r_addr[OFF_W-1:0]),
        .o_merged (w_merged)
    );

    // Address is only presented while the port is in use.
    assign mem_addr  = ((r_state == READ) || (r_state == WRITE))
                       ? w_word_addr : '0;
    assign mem_wr    = (r_state == WRITE);
    assign mem_wdata = mem_wr ? w_merged : '0;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE) || (r_state == ERR);
    assign misalign  = (r_state == ERR);

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: 32-bit lat 1,
// 32-bit lat 3 and 64-bit lat 1 instances.
module tb_store_merge_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // instance A: DATA_W=32, MEM_LAT=1
    logic        rst_a, start_a, wr_a, busy_a, done_a, mis_a;
    logic [31:0] addr_a, wd_a, maddr_a, mwd_a, rd_a;
    logic [1:0]  size_a;
    // instance B: DATA_W=32, MEM_LAT=3
    logic        rst_b, start_b, wr_b, busy_b, done_b, mis_b;
    logic [31:0] addr_b, wd_b, maddr_b, mwd_b, rd_b;
    logic [1:0]  size_b;
    logic [31:0] d1_b = 32'h0, d2_b = 32'h0;
    // instance C: DATA_W=64, MEM_LAT=1
    logic        start_c, wr_c, busy_c, done_c, mis_c;
    logic [31:0] addr_c, maddr_c;
    logic [63:0] wd_c, mwd_c, rd_c;
    logic [1:0]  size_c;

    int wr_cnt_a = 0, wr_cnt_b = 0, wr_cnt_c = 0;
    int w0;

    function automatic logic [31:0] mem32(input logic [31:0] a);
        return (a == 32'h100) ? 32'h11223344 : 32'h0;
    endfunction

    function automatic logic [63:0] mem64(input logic [31:0] a);
        return (a == 32'h200) ? 64'h0123456789ABCDEF : 64'h0;
    endfunction

    assign rd_a = mem32(maddr_a);
    assign rd_c = mem64(maddr_c);
    assign rd_b = d2_b;

    always @(posedge clk) begin
        d1_b <= mem32(maddr_b);
        d2_b <= d1_b;
        if (wr_a) wr_cnt_a <= wr_cnt_a + 1;
        if (wr_b) wr_cnt_b <= wr_cnt_b + 1;
        if (wr_c) wr_cnt_c <= wr_cnt_c + 1;
    end

    store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) u_a (
        .clk(clk), .reset(rst_a), .start(start_a), .addr(addr_a),
        .wdata(wd_a), .size(size_a), .mem_addr(maddr_a),
        .mem_wr(wr_a), .mem_wdata(mwd_a), .mem_rdata(rd_a),
        .busy(busy_a), .done(done_a), .misalign(mis_a)
    );

    store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(3)) u_b (
        .clk(clk), .reset(rst_b), .start(start_b), .addr(addr_b),
        .wdata(wd_b), .size(size_b), .mem_addr(maddr_b),
        .mem_wr(wr_b), .mem_wdata(mwd_b), .mem_rdata(rd_b),
        .busy(busy_b), .done(done_b), .misalign(mis_b)
    );

    store_merge_unit #(.DATA_W(64), .ADDR_W(32), .MEM_LAT(1)) u_c (
        .clk(clk), .reset(rst_a), .start(start_c), .addr(addr_c),
        .wdata(wd_c), .size(size_c), .mem_addr(maddr_c),
        .mem_wr(wr_c), .mem_wdata(mwd_c), .mem_rdata(rd_c),
        .busy(busy_c), .done(done_c), .misalign(mis_c)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ea [3];
    logic [1:0]  es [3];

    initial begin
        ea = '{32'h101, 32'h102, 32'h100};
        es = '{2'd1, 2'd0, 2'd3};
        rst_a = 1'b0; rst_b = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        addr_a = '0; wd_a = '0; size_a = '0;
        addr_b = '0; wd_b = '0; size_b = '0;
        addr_c = '0; wd_c = '0; size_c = '0;
        #2;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_mis", mis_a, 0);
        check("rst_wr", wr_a, 0);
        check("rst_maddr", maddr_a, 0);
        check("rst_mwd", mwd_a, 0);
        check("rst_busy_b", busy_b, 0);
        step(); step();
        rst_a = 1'b1; rst_b = 1'b1;
        step();

        // word store
        addr_a = 32'h100; wd_a = 32'hDEADBEEF; size_a = 2'd0;
        w0 = wr_cnt_a;
        start_a = 1'b1; step(); start_a = 1'b0;
        check("w_t1_wr", wr_a, 1);
        check("w_t1_addr", maddr_a, 32'h100);
        check("w_t1_data", mwd_a, 32'hDEADBEEF);
        check("w_t1_done", done_a, 0);
        check("w_t1_busy", busy_a, 1);
        step();
        check("w_t2_done", done_a, 1);
        check("w_t2_wr", wr_a, 0);
        check("w_t2_mis", mis_a, 0);
        step();
        check("w_t3_busy", busy_a, 0);
        check("w_t3_addr", maddr_a, 0);
        check("w_wrcnt", wr_cnt_a - w0, 1);

        // byte store at top lane
        addr_a = 32'h103; wd_a = 32'h000000AA; size_a = 2'd2;
        start_a = 1'b1; step(); start_a = 1'b0;
        check("b_t1_wr", wr_a, 0);
        check("b_t1_addr", maddr_a, 32'h100);
        check("b_t1_busy", busy_a, 1);
        step();
        check("b_t2_wr", wr_a, 1);
        check("b_t2_addr", maddr_a, 32'h100);
        check("b_t2_data", mwd_a, 32'hAA223344);
        step();
        check("b_t3_done", done_a, 1);
        addr_a = 32'h100; size_a = 2'd0; start_a = 1'b1;
        step(); start_a = 1'b0;
        check("done_start_ign", busy_a, 0);
        check("done_start_wr", wr_a, 0);

        // half store, lat 1
        addr_a = 32'h102; wd_a = 32'h00005566; size_a = 2'd1;
        start_a = 1'b1; step(); start_a = 1'b0;
        check("h_t1_wr", wr_a, 0);
        step();
        check("h_t2_wr", wr_a, 1);
        check("h_t2_data", mwd_a, 32'h55663344);
        step();
        check("h_t3_done", done_a, 1);
        step();

        // rejected requests
        w0 = wr_cnt_a;
        for (int i = 0; i < 3; i++) begin
            addr_a = ea[i]; size_a = es[i]; wd_a = 32'hFFFFFFFF;
            start_a = 1'b1; step(); start_a = 1'b0;
            check($sformatf("err%0d_done", i), done_a, 1);
            check($sformatf("err%0d_mis", i), mis_a, 1);
            check($sformatf("err%0d_wr", i), wr_a, 0);
            step();
            check($sformatf("err%0d_idle", i), {busy_a, done_a}, 0);
        end
        check("err_wrcnt", wr_cnt_a - w0, 0);

        // half store with MEM_LAT=3, start while busy ignored
        w0 = wr_cnt_b;
        addr_b = 32'h102; wd_b = 32'h00005566; size_b = 2'd1;
        start_b = 1'b1; step(); start_b = 1'b0;
        check("l3_t1_wr", wr_b, 0);
        check("l3_t1_addr", maddr_b, 32'h100);
        addr_b = 32'h104; wd_b = 32'hFFFFFFFF; size_b = 2'd0;
        start_b = 1'b1; step(); start_b = 1'b0;
        check("l3_t2_wr", wr_b, 0);
        check("l3_t2_addr", maddr_b, 32'h100);
        step();
        check("l3_t3_wr", wr_b, 0);
        step();
        check("l3_t4_wr", wr_b, 1);
        check("l3_t4_data", mwd_b, 32'h55663344);
        check("l3_t4_addr", maddr_b, 32'h100);
        step();
        check("l3_t5_done", done_b, 1);
        step();
        check("l3_t6_busy", busy_b, 0);
        step(); step();
        check("l3_wrcnt", wr_cnt_b - w0, 1);

        // reset in the middle of a read
        w0 = wr_cnt_b;
        addr_b = 32'h101; wd_b = 32'h00000099; size_b = 2'd2;
        start_b = 1'b1; step(); start_b = 1'b0;
        check("ra_busy", busy_b, 1);
        step();
        #2 rst_b = 1'b0;
        #1;
        check("ra_busy0", busy_b, 0);
        check("ra_addr0", maddr_b, 0);
        check("ra_wr0", wr_b, 0);
        check("ra_mwd0", mwd_b, 0);
        step(); step();
        rst_b = 1'b1;
        repeat (6) step();
        check("ra_wrcnt", wr_cnt_b - w0, 0);
        check("ra_idle", busy_b, 0);

        // 64-bit byte store at offset 6
        w0 = wr_cnt_c;
        addr_c = 32'h206; wd_c = 64'hFFFFFFFFFFFFFF7F; size_c = 2'd2;
        start_c = 1'b1; step(); start_c = 1'b0;
        check("c_t1_addr", maddr_c, 32'h200);
        check("c_t1_wr", wr_c, 0);
        step();
        check("c_t2_wr", wr_c, 1);
        check("c_t2_data", mwd_c, 64'h017F456789ABCDEF);
        step();
        check("c_t3_done", done_c, 1);
        check("c_t3_mis", mis_c, 0);
        step();
        check("c_wrcnt", wr_cnt_c - w0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
